// File: rtl/mem_load_pkg.sv
// Shared types and framing defaults for the UART program loader.
package mem_load_pkg;

   typedef enum logic [1:0] {HUNT, PAYLOAD, EXPECT_STOP} frame_state_e;

   typedef enum logic [2:0] {IDLE, ADDR_L, DATA_L, ADDR_U, DATA_U} bus_state_e;

   typedef enum logic [1:0] {
      CMD_WRITE = 2'b00,
      CMD_RUN   = 2'b01,
      CMD_HALT  = 2'b10
   } cmd_e;

   localparam logic [7:0] START_BYTE_DEF = 8'h55;
   localparam logic [7:0] STOP_BYTE_DEF  = 8'hAA;

endpackage

// File: rtl/uart_frame_rx.sv
// Frame assembler: START, four positional payload bytes, STOP, with an
// inactivity timeout that aborts a partially received frame.
//
// state       | meaning
// HUNT        | waiting for START_BYTE, other bytes ignored
// PAYLOAD     | storing b0..b3 positionally
// EXPECT_STOP | next byte must be STOP_BYTE
module uart_frame_rx
   import mem_load_pkg::*;
#(
   parameter logic [7:0]  START_BYTE  = START_BYTE_DEF,
   parameter logic [7:0]  STOP_BYTE   = STOP_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       frame_done,
   output logic       frame_err,
   output logic       frame_busy,
   output logic [7:0] b0,
   output logic [7:0] b1,
   output logic [7:0] b2,
   output logic [7:0] b3
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   frame_state_e  state;
   logic [1:0]    idx;
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= HUNT;
         idx        <= 2'd0;
         to_cnt     <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         b0         <= 8'h00;
         b1         <= 8'h00;
         b2         <= 8'h00;
         b3         <= 8'h00;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            HUNT: begin
               to_cnt <= '0;
               if (rx_valid && rx_data == START_BYTE) begin
                  state <= PAYLOAD;
                  idx   <= 2'd0;
               end
            end
            PAYLOAD, EXPECT_STOP: begin
               // A byte arriving on the expiry cycle wins over the timeout
               if (rx_valid) begin
                  to_cnt <= '0;
                  if (state == PAYLOAD) begin
                     case (idx)
                        2'd0:    b0 <= rx_data;
                        2'd1:    b1 <= rx_data;
                        2'd2:    b2 <= rx_data;
                        default: b3 <= rx_data;
                     endcase
                     idx <= idx + 2'd1;
                     if (idx == 2'd3) state <= EXPECT_STOP;
                  end else begin
                     if (rx_data == STOP_BYTE) frame_done <= 1'b1;
                     else                      frame_err  <= 1'b1;
                     state <= HUNT;
                  end
               end else if (to_cnt == TO_LAST) begin
                  frame_err <= 1'b1;
                  to_cnt    <= '0;
                  state     <= HUNT;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   assign frame_busy = (state != HUNT);

endmodule

// File: rtl/mem_load_ctrl.sv
// Shared memory port sequencer: decodes loader frames, runs the 4-cycle
// split write, and gates the CPU onto the bus only while it is out of reset.
//
// state  | meaning
// IDLE   | bus owned by CPU when running, else driven to zero
// ADDR_L | loader drives address
// DATA_L | loader commits data[5:0]
// ADDR_U | loader drives address
// DATA_U | loader commits data[11:6]
module mem_load_ctrl
   import mem_load_pkg::*;
#(
   parameter logic [7:0]  START_BYTE  = START_BYTE_DEF,
   parameter logic [7:0]  STOP_BYTE   = STOP_BYTE_DEF,
   parameter int unsigned TIMEOUT_CYC = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic [9:0] cpu_addr_data,
   input  logic       cpu_read_write,
   input  logic       cpu_write_commit,
   output logic [9:0] mem_addr_data,
   output logic       mem_read_write,
   output logic       mem_write_commit,
   output logic       cpu_rst,
   output logic       busy,
   output logic [7:0] err_cnt
);

   logic       frame_done, frame_err, frame_busy;
   logic [7:0] b0, b1, b2, b3;

   uart_frame_rx #(
      .START_BYTE  (START_BYTE),
      .STOP_BYTE   (STOP_BYTE),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_frame (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .frame_busy (frame_busy),
      .b0         (b0),
      .b1         (b1),
      .b2         (b2),
      .b3         (b3)
   );

   logic [1:0]  cmd;
   logic [9:0]  addr;
   logic [11:0] data;
   bus_state_e  bus_state;
   logic [9:0]  addr_q;
   logic [11:0] data_q;
   logic        run_pend;
   logic        wr_go, dec_err;

   assign cmd  = b0[7:6];
   assign addr = {b0[1:0], b1};
   assign data = {b2, b3[3:0]};

   always_comb begin
      wr_go   = 1'b0;
      dec_err = 1'b0;
      if (frame_done) begin
         case (cmd)
            CMD_WRITE: begin
               if (cpu_rst && bus_state == IDLE) wr_go   = 1'b1;
               else                              dec_err = 1'b1;
            end
            CMD_RUN, CMD_HALT: ;
            default: dec_err = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus_state <= IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         cpu_rst   <= 1'b1;
         run_pend  <= 1'b0;
         err_cnt   <= 8'h00;
      end else begin
         case (bus_state)
            IDLE: if (wr_go) begin
               bus_state <= ADDR_L;
               addr_q    <= addr;
               data_q    <= data;
            end
            ADDR_L:  bus_state <= DATA_L;
            DATA_L:  bus_state <= ADDR_U;
            ADDR_U:  bus_state <= DATA_U;
            default: bus_state <= IDLE;
         endcase

         // RUN during an active write is held until the bus is back in IDLE
         if (frame_done && cmd == CMD_HALT) begin
            cpu_rst  <= 1'b1;
            run_pend <= 1'b0;
         end else if (frame_done && cmd == CMD_RUN) begin
            if (bus_state == IDLE) cpu_rst  <= 1'b0;
            else                   run_pend <= 1'b1;
         end else if (run_pend && bus_state == IDLE) begin
            cpu_rst  <= 1'b0;
            run_pend <= 1'b0;
         end

         if ((frame_err || dec_err) && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   always_comb begin
      mem_addr_data    = '0;
      mem_read_write   = 1'b0;
      mem_write_commit = 1'b0;
      case (bus_state)
         IDLE: if (!cpu_rst) begin
            mem_addr_data    = cpu_addr_data;
            mem_read_write   = cpu_read_write;
            mem_write_commit = cpu_write_commit;
         end
         ADDR_L, ADDR_U: begin
            mem_addr_data  = addr_q;
            mem_read_write = 1'b1;
         end
         DATA_L: begin
            mem_addr_data    = {4'b0, data_q[5:0]};
            mem_read_write   = 1'b1;
            mem_write_commit = 1'b1;
         end
         DATA_U: begin
            mem_addr_data    = {4'b0, data_q[11:6]};
            mem_read_write   = 1'b1;
            mem_write_commit = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = frame_busy || (bus_state != IDLE);

endmodule
